cmos_pixel_capture: RTL and testbench
=====================================

CMOS_PIXEL_CAPTURE -- requirements
Module: cmos_pixel_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320: pixels per line kept; later pixels discarded.
REQ-002 SHALL have parameter V_ACTIVE, default 240: lines per frame kept; later lines discarded.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two: number of pixel-buffer entries.
REQ-004 SHALL have parameter SKIP_FRAMES, default 2: frames discarded after reset while the sensor settles.
REQ-005 SHALL have port clk, input, 1: the single clock (main clock), faster than 2x CMOS_PCLK.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port CMOS_PCLK, input, 1: sensor pixel clock, treated as asynchronous data.
REQ-008 SHALL have port CMOS_HREF, input, 1: line-valid, active high.
REQ-009 SHALL have port CMOS_VSYNC, input, 1: frame sync; a rising edge marks frame end.
REQ-010 SHALL have port CMOS_DQ, input, 8: sensor byte bus.
REQ-011 SHALL have port iEn, input, 1: single-cycle pop request.
REQ-012 SHALL have port oData, output, 36: [35:26] X, [25:16] Y, [15:0] RGB565.
REQ-013 SHALL have port oEmpty, output, 1: buffer holds no pixel.
REQ-014 SHALL have port oOverflow, output, 1: sticky flag, pixel dropped on full buffer.

Function
REQ-015 SHALL pass CMOS_PCLK, CMOS_HREF, CMOS_VSYNC and CMOS_DQ through two clk flops before use, keeping DQ aligned with PCLK.
REQ-016 SHALL detect a PCLK rising edge as synced PCLK high with the previous sample low, and sample DQ only on that cycle while synced HREF=1.
REQ-017 SHALL use a byte-phase bit: phase 0 stores the byte as RGB565[15:8]; phase 1 forms the pixel with the byte as [7:0], then toggles.
REQ-018 SHALL push {X,Y,pixel} the cycle after the phase-1 sample when X<H_ACTIVE, Y<V_ACTIVE and the skip count is exhausted, then increment X (X saturates at 1023).
REQ-019 SHALL, on a synced HREF falling edge, set X=0 and phase=0 and increment Y (Y saturates at 1023).
REQ-020 SHALL, on a synced VSYNC rising edge, set X=0, Y=0 and phase=0 and increment the skip counter, saturating at SKIP_FRAMES.
REQ-021 SHALL discard all pixels until SKIP_FRAMES VSYNC rising edges have occurred since reset; SKIP_FRAMES=0 disables skipping.
REQ-022 SHALL use a control FSM with states IDLE (waiting for skip exhaustion), WAIT_FRAME (waiting for VSYNC low), LINE (HREF high, capturing) and BLANK (HREF low, between lines).
REQ-023 SHALL make FSM transitions IDLE->WAIT_FRAME on skip done, WAIT_FRAME->BLANK on VSYNC low, BLANK->LINE on HREF rise, LINE->BLANK on HREF fall, and any state->WAIT_FRAME on VSYNC rise once skip is done.
REQ-024 SHALL, on iEn=1 with oEmpty=0, pop the head entry to oData, with the value valid on the next clk edge and held until the next pop.
REQ-025 SHALL ignore iEn when oEmpty=1, leaving oData unchanged.
REQ-026 SHALL, on push when full, drop the pixel and set oOverflow=1 until reset.
REQ-027 SHALL perform both operations on a simultaneous push and pop when full, so no drop occurs and the count is unchanged.
REQ-028 SHALL, on a partial pixel at HREF fall (phase=1 pending), discard the stored high byte.
REQ-029 SHALL have a latency of 4 clk from the PCLK pin rising edge of the second byte to oEmpty falling on an empty buffer.

Reset
REQ-030 SHALL asynchronously clear all state on rst_n=0: oData=0, oEmpty=1, oOverflow=0, X=Y=0, phase=0, skip count=0, FSM=IDLE, and buffer pointers and count=0.
REQ-031 SHALL discard any frame in progress on reset mid-frame and restart skip counting.

Structure
REQ-032 SHALL place the field widths (X=10, Y=10, PIX=16, word=36) and the FSM state encodings in the shared package cmos_pkg.
REQ-033 SHALL implement the buffer as a single sub-module pixel_fifo (synchronous, one clock, first-word-latched output, full/empty/count).

Verification
REQ-034 SHALL verify: after reset, bytes 0xF8,0x00 on line 0 of frame 3 with SKIP_FRAMES=2 -> pop gives oData={X=0,Y=0,0xF800}.
REQ-035 SHALL verify: frames 1-2 fully driven with SKIP_FRAMES=2 -> oEmpty stays 1 throughout.
REQ-036 SHALL verify: a 330-pixel line with H_ACTIVE=320 -> exactly 320 pushes, last X=319; the next line starts at Y=1, X=0.
REQ-037 SHALL verify: no pops while 9 pixels arrive with FIFO_DEPTH=8 -> oOverflow=1 and popped X values 0..7.
REQ-038 SHALL verify: HREF falling after an odd byte count (3 bytes) -> one pixel pushed and the stray byte discarded.
REQ-039 SHALL verify: rst_n low mid-line, then release -> oEmpty=1, oOverflow=0, oData=0, and capture resumes only after SKIP_FRAMES new VSYNC edges.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared widths, output word layout and capture FSM encodings for the CMOS pixel capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmos_pkg;

  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int PIX_W  = 16;
  localparam int WORD_W = X_W + Y_W + PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,  // skip frames not yet exhausted
    ST_WAIT_FRAME = 2'd1,  // waiting for VSYNC to drop before a usable frame
    ST_LINE       = 2'd2,  // HREF high, capturing
    ST_BLANK      = 2'd3   // HREF low, between lines
  } cap_state_t;

  // Output word: [35:26] X, [25:16] Y, [15:0] RGB565
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [PIX_W-1:0] pix;
  } pix_word_t;

  // Coordinate counters stop at their top value rather than wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel buffer with a registered head word that is loaded on each accepted pop.
// Latency: push visible in count/empty next clk; popped word valid on pop_dat the clk after the pop.
// Backpressure: push while full is ignored unless a pop is accepted in the same cycle.
//
// Ports: clk, rst_n; push/push_dat write side; pop read request; pop_dat held head word;
//        empty, full, count occupancy status.
module pixel_fifo
  import cmos_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_dat <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        pop_dat <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmos_pixel_capture.sv
// Captures RGB565 pixels from an 8-bit CMOS sensor bus into a small buffer tagged with X/Y.
// Latency: 4 clk from the PCLK pin edge of a pixel's second byte to oEmpty falling on an empty buffer.
// Backpressure: none toward the sensor; a pixel arriving on a full buffer is dropped and oOverflow sticks.
//
// Ports: clk, rst_n; CMOS_PCLK/HREF/VSYNC/DQ sensor pins (asynchronous);
//        iEn pop request; oData {X,Y,RGB565}; oEmpty; oOverflow (sticky).
module cmos_pixel_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CMOS_PCLK,
  input  logic              CMOS_HREF,
  input  logic              CMOS_VSYNC,
  input  logic [7:0]        CMOS_DQ,
  input  logic              iEn,
  output logic [WORD_W-1:0] oData,
  output logic              oEmpty,
  output logic              oOverflow
);

  localparam logic [7:0] SKIP_LIM = 8'(SKIP_FRAMES);

  // Two-flop synchronisers; DQ goes through the same depth so it stays aligned with PCLK.
  logic [1:0] pclk_sync, href_sync, vsync_sync;
  logic [7:0] dq_s1, dq_s2;
  logic       pclk_d, href_d, vsync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sync  <= '0;
      href_sync  <= '0;
      vsync_sync <= '0;
      dq_s1      <= '0;
      dq_s2      <= '0;
      pclk_d     <= 1'b0;
      href_d     <= 1'b0;
      vsync_d    <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], CMOS_PCLK};
      href_sync  <= {href_sync[0], CMOS_HREF};
      vsync_sync <= {vsync_sync[0], CMOS_VSYNC};
      dq_s1      <= CMOS_DQ;
      dq_s2      <= dq_s1;
      pclk_d     <= pclk_sync[1];
      href_d     <= href_sync[1];
      vsync_d    <= vsync_sync[1];
    end
  end

  logic pclk_rise, href_rise, href_fall, vsync_rise;
  assign pclk_rise  = pclk_sync[1] && !pclk_d;
  assign href_rise  = href_sync[1] && !href_d;
  assign href_fall  = !href_sync[1] && href_d;
  assign vsync_rise = vsync_sync[1] && !vsync_d;

  cap_state_t     state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           phase;
  logic [7:0]     hi_byte;
  logic [7:0]     skip_cnt;
  logic           push_vld;
  pix_word_t      push_word;
  logic           skip_done;
  logic           keep;

  assign skip_done = (skip_cnt == SKIP_LIM);
  assign keep      = (state == ST_LINE) && skip_done &&
                     (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      phase     <= 1'b0;
      hi_byte   <= '0;
      skip_cnt  <= '0;
      push_vld  <= 1'b0;
      push_word <= '0;
    end else begin
      push_vld <= 1'b0;

      // Counters and byte assembly; frame end beats line end beats byte sample.
      if (vsync_rise) begin
        x     <= '0;
        y     <= '0;
        phase <= 1'b0;
        if (!skip_done) skip_cnt <= skip_cnt + 8'd1;
      end else if (href_fall) begin
        // Clearing phase drops any unpaired high byte left at the end of the line.
        x     <= '0;
        phase <= 1'b0;
        y     <= sat_inc10(y);
      end else if (pclk_rise && href_sync[1]) begin
        if (!phase) begin
          hi_byte <= dq_s2;
          phase   <= 1'b1;
        end else begin
          phase         <= 1'b0;
          push_vld      <= keep;
          push_word.x   <= x;
          push_word.y   <= y;
          push_word.pix <= {hi_byte, dq_s2};
          x             <= sat_inc10(x);
        end
      end

      if (vsync_rise && skip_done) begin
        state <= ST_WAIT_FRAME;
      end else begin
        case (state)
          ST_IDLE:       if (skip_done)         state <= ST_WAIT_FRAME;
          ST_WAIT_FRAME: if (!vsync_sync[1])    state <= ST_BLANK;
          ST_BLANK:      if (href_rise)         state <= ST_LINE;
          ST_LINE:       if (href_fall)         state <= ST_BLANK;
          default:                              state <= ST_IDLE;
        endcase
      end
    end
  end

  logic                        fifo_empty;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        pop_ok;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld),
    .push_dat (push_word),
    .pop      (iEn),
    .pop_dat  (oData),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign oEmpty = fifo_empty;
  assign pop_ok = iEn && (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oOverflow <= 1'b0;
    end else if (push_vld && fifo_full && !pop_ok) begin
      oOverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Randomised bench for cmos_pixel_capture against a queue-based model of frames, lines and pixels.
// Latency: measures the second-byte-to-oEmpty delay once.
// Backpressure: a background drainer pops whenever enabled; disabled for the overflow case.
`timescale 1ns/1ps
module tb_cmos_pixel_capture;

  localparam int H     = 320;
  localparam int V     = 240;
  localparam int DEPTH = 8;
  localparam int SKIP  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CMOS_PCLK, CMOS_HREF, CMOS_VSYNC;
  logic [7:0]  CMOS_DQ;
  logic        iEn;
  logic [35:0] oData;
  logic        oEmpty, oOverflow;

  always #5 clk = ~clk;

  cmos_pixel_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .FIFO_DEPTH  (DEPTH),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CMOS_PCLK  (CMOS_PCLK),
    .CMOS_HREF  (CMOS_HREF),
    .CMOS_VSYNC (CMOS_VSYNC),
    .CMOS_DQ    (CMOS_DQ),
    .iEn        (iEn),
    .oData      (oData),
    .oEmpty     (oEmpty),
    .oOverflow  (oOverflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model: frames ended since reset, current line index, expected words in order.
  logic [35:0] exp_q[$];
  int          frames_seen;
  int          model_y;
  bit          exp_ovf;
  logic [7:0]  lb[$];

  // Drainer state and statistics gathered from popped words.
  bit          drain_en;
  bit          pop_pend;
  bit          saw_nonempty;
  int          n_popped;
  logic [35:0] first_word;
  int          pop_cnt_y [16];
  int          last_x_y  [16];
  int          first_x_y [16];
  int          px, py;

  task automatic clear_stats();
    n_popped = 0;
    for (int i = 0; i < 16; i++) begin
      pop_cnt_y[i] = 0;
      last_x_y[i]  = -1;
      first_x_y[i] = -1;
    end
  endtask

  initial begin
    iEn      = 1'b0;
    pop_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!oEmpty) saw_nonempty = 1'b1;
      if (pop_pend) begin
        pop_pend = 1'b0;
        check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("pop_data", oData, exp_q.pop_front());
        if (n_popped == 0) first_word = oData;
        n_popped++;
        px = int'(oData[35:26]);
        py = int'(oData[25:16]);
        if (py < 16) begin
          pop_cnt_y[py]++;
          last_x_y[py] = px;
          if (first_x_y[py] < 0) first_x_y[py] = px;
        end
      end
      if (drain_en && !oEmpty && rst_n) begin
        iEn      = 1'b1;
        pop_pend = 1'b1;
      end else begin
        iEn = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit measure);
    int k;
    @(negedge clk);
    CMOS_DQ   = b;
    CMOS_PCLK = 1'b0;
    repeat (2) @(negedge clk);
    CMOS_PCLK = 1'b1;
    if (measure) begin
      k = 0;
      while (oEmpty && k < 12) begin
        @(negedge clk);
        k++;
      end
      check("latency", 64'(k), 64'd4);
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic make_line(input int npix, input int extra);
    for (int i = 0; i < 2 * npix + extra; i++) lb.push_back(8'($urandom));
  endtask

  // Model first, from the byte list, then drive the pins.
  task automatic drive_line(input bit measure, input bit cap_limited);
    for (int i = 0; i < lb.size() / 2; i++) begin
      if (frames_seen >= SKIP && i < H && model_y < V) begin
        if (cap_limited && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back({10'(i), 10'(model_y), lb[2*i], lb[2*i+1]});
      end
    end
    model_y++;
    @(negedge clk);
    CMOS_HREF = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < lb.size(); i++) begin
      send_byte(lb[i], measure && i == 1);
      if (measure && i == 1) drain_en = 1'b1;
    end
    @(negedge clk);
    CMOS_HREF = 1'b0;
    repeat (6) @(negedge clk);
    lb.delete();
  endtask

  task automatic end_frame();
    @(negedge clk);
    CMOS_VSYNC = 1'b1;
    repeat (8) @(negedge clk);
    CMOS_VSYNC = 1'b0;
    repeat (8) @(negedge clk);
    frames_seen++;
    model_y = 0;
  endtask

  task automatic skipped_frames();
    for (int f = 0; f < SKIP; f++) begin
      for (int l = 0; l < 2; l++) begin
        make_line($urandom_range(2, 10), 0);
        drive_line(1'b0, 1'b0);
      end
      end_frame();
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !oEmpty || pop_pend) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    frames_seen = 0;
    model_y     = 0;
    exp_ovf     = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    CMOS_PCLK  = 1'b0;
    CMOS_HREF  = 1'b0;
    CMOS_VSYNC = 1'b0;
    CMOS_DQ    = 8'h00;
    drain_en   = 1'b0;
    saw_nonempty = 1'b0;
    model_reset();
    clear_stats();
    repeat (5) @(negedge clk);
    check("rst_empty", 64'(oEmpty), 64'd1);
    check("rst_ovf", 64'(oOverflow), 64'd0);
    check("rst_data", oData, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Settling frames must not produce anything.
    saw_nonempty = 1'b0;
    skipped_frames();
    check("skip_empty", 64'(saw_nonempty), 64'd0);

    // Frame 3, line 0: F8,00 first, 330 pixels in total, overlong tail discarded.
    lb.push_back(8'hF8);
    lb.push_back(8'h00);
    make_line(329, 0);
    drive_line(1'b1, 1'b0);
    wait_drain();
    check("first_word", first_word, {10'd0, 10'd0, 16'hF800});
    check("line0_count", 64'(pop_cnt_y[0]), 64'd320);
    check("line0_last_x", 64'(last_x_y[0]), 64'd319);

    make_line(5, 0);
    drive_line(1'b0, 1'b0);
    wait_drain();
    check("line1_first_x", 64'(first_x_y[1]), 64'd0);
    check("line1_count", 64'(pop_cnt_y[1]), 64'd5);

    // Odd byte count: one pixel, stray byte must not leak into the next line.
    make_line(1, 1);
    drive_line(1'b0, 1'b0);
    make_line(4, 0);
    drive_line(1'b0, 1'b0);
    wait_drain();
    check("odd_line_count", 64'(pop_cnt_y[2]), 64'd1);
    check("after_odd_count", 64'(pop_cnt_y[3]), 64'd4);
    check("no_ovf_yet", 64'(oOverflow), 64'(exp_ovf));

    // Nine pixels with nobody popping.
    drain_en = 1'b0;
    make_line(9, 0);
    drive_line(1'b0, 1'b1);
    check("ovf_set", 64'(oOverflow), 64'(exp_ovf));
    drain_en = 1'b1;
    wait_drain();
    check("ovf_line_count", 64'(pop_cnt_y[4]), 64'd8);
    check("ovf_line_last_x", 64'(last_x_y[4]), 64'd7);
    check("ovf_sticky", 64'(oOverflow), 64'd1);

    // Reset in the middle of a line that is being captured.
    drain_en = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    CMOS_HREF = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    CMOS_HREF = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("midrst_empty", 64'(oEmpty), 64'd1);
    check("midrst_ovf", 64'(oOverflow), 64'd0);
    check("midrst_data", oData, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_stats();
    saw_nonempty = 1'b0;
    skipped_frames();
    check("skip_after_rst", 64'(saw_nonempty), 64'd0);
    drain_en = 1'b1;
    make_line(6, 0);
    drive_line(1'b0, 1'b0);
    make_line($urandom_range(3, 12), 0);
    drive_line(1'b0, 1'b0);
    wait_drain();
    check("resume_count", 64'(pop_cnt_y[0]), 64'd6);
    check("resume_first_x", 64'(first_x_y[0]), 64'd0);
    check("final_ovf", 64'(oOverflow), 64'(exp_ovf));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
